// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
//   Interrupt-acknowledge sequencer for the 8259A PIC core. It raises INT
//   when the priority resolver requests service. It then decodes the CPU's
//   INTA pulse train and freezes IRR/priority while the acknowledge runs.
//   It sets the ISR bit, drives the vector byte(s) onto the internal data
//   bus, and issues the automatic-EOI clear at the end of the cycle.
//
//   Optional feature macro: MCS80_MODE_EN
//     defined   : 3-pulse MCS-80/85 CALL sequence available (mode_8086=0)
//     undefined : 8086/88 two-pulse sequence only; mode_8086/adi/vec_lo ignored
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   inta_n          CPU INTA, active-low, asynchronous to clk
//   int_req         level request from the priority resolver
//   int_index       winning IR index
//   mode_8086       ICW4[0]: 1 = 8086/88, 0 = MCS-80/85
//   aeoi            ICW4[1]: automatic EOI
//   adi             ICW1[2]: call address interval (1 = 4, 0 = 8)
//   vec_hi          ICW2
//   vec_lo          ICW1 A7..A5
//   int_out         INT to CPU
//   freeze          hold IRR/priority during the acknowledge
//   isr_set         pulse: set ISR bit isr_index
//   isr_index       latched serviced index
//   aeoi_clr        pulse: clear ISR bit isr_index
//   data_out        byte for the internal data bus
//   data_oe         data_out valid / bus drive enable
//   spurious        pulse: spurious acknowledge detected
module pic_inta_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SPURIOUS_INDEX = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] int_index,
  input  logic       mode_8086,
  input  logic       aeoi,
  input  logic       adi,
  input  logic [7:0] vec_hi,
  input  logic [2:0] vec_lo,
  output logic       int_out,
  output logic       freeze,
  output logic       isr_set,
  output logic [2:0] isr_index,
  output logic       aeoi_clr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       spurious
);

  localparam logic [2:0] SPUR_IDX = SPURIOUS_INDEX[2:0];

  typedef enum logic [1:0] {IDLE, REQ, ACK, DONE} state_t;

  state_t r_state, w_state_nxt;

  // inta_n synchroniser plus edge register
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_inta_q;
  logic                   w_inta_s, w_fall, w_rise, w_inflight;

  // registered outputs and their next values
  logic       r_int_out, r_freeze, r_isr_set, r_aeoi_clr, r_data_oe, r_spurious;
  logic [2:0] r_isr_index;
  logic [7:0] r_data_out;
  logic       w_int_out, w_freeze, w_isr_set, w_aeoi_clr, w_data_oe, w_spurious;
  logic [2:0] w_isr_index;
  logic [7:0] w_data_out;

  // per-cycle context: pulse count, spurious flag, configuration shadows
  logic [1:0] r_k, w_k;
  logic       r_spur_lat, w_spur_lat;
  logic       r_mode_8086, r_adi, w_mode_8086, w_adi;
  logic [7:0] r_vec_hi, w_vec_hi;
  logic [2:0] r_vec_lo, w_vec_lo;

  logic [1:0] w_pulses;
  logic       w_first_oe;
  logic [7:0] w_first_byte;
  logic [7:0] w_vec_byte;
  logic [2:0] w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_inta_q <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], inta_n};
      r_inta_q <= w_inta_s;
    end
  end

  assign w_inta_s   = r_sync[SYNC_STAGES-1];
  assign w_fall     = r_inta_q & ~w_inta_s;
  assign w_rise     = ~r_inta_q & w_inta_s;
  // A falling INTA still travelling through the synchroniser: the request
  // must not be treated as withdrawn, so that a late drop becomes spurious.
  assign w_inflight = ~(&r_sync);

  assign w_idx = int_req ? int_index : SPUR_IDX;

`ifdef MCS80_MODE_EN
  assign w_pulses     = r_mode_8086 ? 2'd2 : 2'd3;
  // first pulse is decided in REQ, before the shadows are loaded
  assign w_first_oe   = ~mode_8086;
  assign w_first_byte = 8'hCD;
  always_comb begin
    w_vec_byte = r_vec_hi;
    if (r_mode_8086)
      w_vec_byte = {r_vec_hi[7:3], r_isr_index};
    else if (r_k == 2'd2)
      w_vec_byte = r_adi ? {r_vec_lo, r_isr_index, 2'b00}
                         : {r_vec_lo[2:1], r_isr_index, 3'b000};
  end
`else
  logic w_unused;
  assign w_pulses     = 2'd2;
  assign w_first_oe   = 1'b0;
  assign w_first_byte = 8'h00;
  assign w_vec_byte   = {r_vec_hi[7:3], r_isr_index};
  assign w_unused     = ^{mode_8086, adi, vec_lo, r_mode_8086, r_adi, r_vec_lo,
                          r_vec_hi[2:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_int_out   = r_int_out;
    w_freeze    = r_freeze;
    w_isr_set   = 1'b0;
    w_isr_index = r_isr_index;
    w_aeoi_clr  = 1'b0;
    w_data_out  = r_data_out;
    w_data_oe   = r_data_oe;
    w_spurious  = 1'b0;
    w_spur_lat  = r_spur_lat;
    w_k         = r_k;
    w_mode_8086 = r_mode_8086;
    w_adi       = r_adi;
    w_vec_hi    = r_vec_hi;
    w_vec_lo    = r_vec_lo;
    case (r_state)
      IDLE: begin
        if (int_req) begin
          w_int_out   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_fall) begin
          w_freeze    = 1'b1;
          w_isr_index = w_idx;
          w_isr_set   = int_req;
          w_spurious  = ~int_req;
          w_spur_lat  = ~int_req;
          w_mode_8086 = mode_8086;
          w_adi       = adi;
          w_vec_hi    = vec_hi;
          w_vec_lo    = vec_lo;
          w_k         = 2'd1;
          if (w_first_oe) begin
            w_data_oe  = 1'b1;
            w_data_out = w_first_byte;
          end
          w_state_nxt = ACK;
        end else if (!int_req && !w_inflight) begin
          w_int_out   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      ACK: begin
        if (w_fall) begin
          w_data_oe  = 1'b1;
          w_data_out = w_vec_byte;
        end else if (w_rise) begin
          w_data_oe = 1'b0;
          if (r_k == w_pulses) begin
            w_int_out   = 1'b0;
            w_freeze    = 1'b0;
            w_aeoi_clr  = aeoi & ~r_spur_lat;
            w_state_nxt = DONE;
          end else begin
            w_k = r_k + 2'd1;
          end
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_out   <= 1'b0;
      r_freeze    <= 1'b0;
      r_isr_set   <= 1'b0;
      r_isr_index <= '0;
      r_aeoi_clr  <= 1'b0;
      r_data_out  <= '0;
      r_data_oe   <= 1'b0;
      r_spurious  <= 1'b0;
      r_spur_lat  <= 1'b0;
      r_k         <= '0;
      r_mode_8086 <= 1'b0;
      r_adi       <= 1'b0;
      r_vec_hi    <= '0;
      r_vec_lo    <= '0;
    end else begin
      r_int_out   <= w_int_out;
      r_freeze    <= w_freeze;
      r_isr_set   <= w_isr_set;
      r_isr_index <= w_isr_index;
      r_aeoi_clr  <= w_aeoi_clr;
      r_data_out  <= w_data_out;
      r_data_oe   <= w_data_oe;
      r_spurious  <= w_spurious;
      r_spur_lat  <= w_spur_lat;
      r_k         <= w_k;
      r_mode_8086 <= w_mode_8086;
      r_adi       <= w_adi;
      r_vec_hi    <= w_vec_hi;
      r_vec_lo    <= w_vec_lo;
    end
  end

  assign int_out   = r_int_out;
  assign freeze    = r_freeze;
  assign isr_set   = r_isr_set;
  assign isr_index = r_isr_index;
  assign aeoi_clr  = r_aeoi_clr;
  assign data_out  = r_data_out;
  assign data_oe   = r_data_oe;
  assign spurious  = r_spurious;

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Clocked interrupt-acknowledge sequencer for the 8259A PIC core.
- Raises INT to the CPU when the priority resolver requests service.
- Decodes the CPU's INTA pulse train, freezes IRR/priority, sets the ISR bit, and drives the vector byte(s) onto the internal data bus.
- Issues the automatic-EOI clear at the end of the cycle.
- Sits between the priority resolver, in-service register and data bus buffer.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising inta_n (minimum 2).
- SPURIOUS_INDEX, 7, index reported when the request vanishes before the first INTA.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- inta_n  in  1  CPU interrupt acknowledge, active-low, asynchronous
- int_req  in  1  level request from the priority resolver
- int_index  in  3  winning IR index from the priority resolver
- mode_8086  in  1  ICW4 bit 0 (1 = 8086/88 mode, 0 = MCS-80/85 mode)
- aeoi  in  1  ICW4 bit 1, automatic EOI
- adi  in  1  ICW1 bit 2, call address interval (1 = 4, 0 = 8)
- vec_hi  in  8  ICW2 (8086: T7..T3 in bits 7:3; MCS-80: A15..A8)
- vec_lo  in  3  ICW1 A7..A5 (MCS-80 only)
- int_out  out  1  INT to CPU
- freeze  out  1  holds IRR/priority stable during the acknowledge cycle
- isr_set  out  1  one-cycle pulse: set ISR bit isr_index
- isr_index  out  3  latched serviced index
- aeoi_clr  out  1  one-cycle pulse: clear ISR bit isr_index
- data_out  out  8  byte driven to the internal data bus
- data_oe  out  1  data_out valid / bus drive enable
- spurious  out  1  one-cycle pulse: spurious acknowledge detected

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, synchroniser flops 1. Reset mid-cycle aborts immediately with no isr_set or aeoi_clr.
- inta_n passes through SYNC_STAGES flops plus an edge register. fall/rise are one-cycle strobes.
- Pulse count N: N=2 when mode_8086=1; N=3 otherwise.
- IDLE:
  - int_req=1 → int_out=1 on the next clock, go to REQ.
  - fall strobe while in IDLE is ignored.
- REQ:
  - int_req=0 with no fall → int_out=0, back to IDLE.
  - fall → freeze=1.
  - If int_req=1: latch isr_index=int_index and pulse isr_set the next cycle.
  - If int_req=0: isr_index=SPURIOUS_INDEX, pulse spurious, no isr_set.
  - Sample mode_8086, adi, vec_hi and vec_lo into shadow regs. Later config changes do not affect this cycle.
  - Go to ACK, pulse count=1.
- ACK (per pulse k = 1..N):
  - data_oe rises the cycle after fall and drops the cycle after rise.
  - 8086, k=1: data_oe stays 0.
  - 8086, k=2: data_out={vec_hi[7:3], isr_index}.
  - MCS-80, k=1: data_out=8'hCD.
  - MCS-80, k=2: data_out={vec_lo,isr_index,2'b00} if adi=1; {vec_lo[2:1],isr_index,3'b000} if adi=0.
  - MCS-80, k=3: data_out=vec_hi.
  - On rise of pulse k<N: increment k and wait for the next fall.
  - On rise of pulse N: int_out=0, freeze=0, go to DONE.
- DONE (one cycle):
  - Pulse aeoi_clr if aeoi=1 and not spurious.
  - Go to IDLE; int_out may re-raise the following cycle.
- data_out holds its last value when data_oe=0. Bench checks data_out only while data_oe=1.
- int_req toggling during ACK is ignored because freeze is high.
- Fall and rise strobes cannot coincide; a pulse shorter than SYNC_STAGES+1 clocks may be lost, and this is not required to be detected.

Optional Feature:
- MCS80_MODE_EN defined: 3-pulse MCS-80/85 CALL sequence supported as above.
- MCS80_MODE_EN undefined: mode_8086, adi and vec_lo are ignored; N is fixed at 2 and only the 8086 sequence exists.

Test Plan:
- 8086 normal: vec_hi=8'h40, int_req=1, int_index=3, two INTA pulses → int_out=1 one cycle after int_req; isr_set with isr_index=3 after pulse 1; data_out=8'h43 with data_oe=1 in pulse 2; int_out=0 after pulse 2.
- AEOI: same stimulus with aeoi=1, int_index=5, vec_hi=8'h08 → data_out=8'h0D; single aeoi_clr pulse in DONE, isr_index=5.
- Spurious: int_req raised then dropped one clock before the first INTA fall → spurious pulse, no isr_set, data_out=8'h47 (vec_hi=8'h40).
- Request withdrawn: int_req high for 3 clocks with no INTA → int_out falls, no freeze, state IDLE.
- MCS-80 (macro on): mode_8086=0, adi=1, vec_lo=3'b101, vec_hi=8'h12, index 2 → bytes CD, A8, 12 on the three pulses.
- Reset mid-sequence: rst_n low between INTA pulses → all outputs 0 immediately; next int_req starts a fresh cycle with correct vector.
